ram_fifo_ctl: RTL
=================

Name: ram_fifo_ctl

Overview:
- Stream FIFO controller that owns the 8k x 16 dual-port block RAM.
- Write side: port A only. Read side: port B only.
- Turns a valid/ready input stream into a valid/ready output stream. The output is first-word-fall-through through a 2-entry output buffer that absorbs the RAM's 1-cycle unregistered read latency.
- Sits between the sample producers (DSP/decimator chain) and the host/packet readout logic.

Parameters:
AW, 13, RAM address width; DEPTH = 2**AW words
DW, 16, data width
AFULL, 7936, almost_full threshold on ram_cnt (words resident in RAM)

Ports:
clk  in  1  master clock
rst  in  1  synchronous active-high reset; also drives the RAM rst pin
din  in  DW  input word
din_valid  in  1  input word present
din_ready  out  1  FIFO can accept a word this cycle
dout  out  DW  output word (head of FIFO)
dout_valid  out  1  dout holds a valid word
dout_ready  in  1  consumer takes dout this cycle
level  out  AW+1  total words held (RAM + in-flight read + output buffer)
almost_full  out  1  ram_cnt >= AFULL
ram_aa  out  AW  RAM port A address (write pointer)
ram_dia  out  DW  RAM port A write data
ram_cea  out  1  RAM port A enable
ram_wea  out  1  RAM port A write enable
ram_ab  out  AW  RAM port B address (read pointer)
ram_ceb  out  1  RAM port B enable
ram_dob  in  DW  RAM port B read data, valid one clock after ram_ceb

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: wptr=0, rptr=0, ram_cnt=0, rd_pend=0, obuf empty, dout=0, dout_valid=0, level=0, almost_full=0.
- din_ready: registered; equals (ram_cnt != DEPTH) after each edge; 0 during and after reset until the first edge with rst=0.
- Push: push = din_valid & din_ready (combinational).
  - ram_cea = ram_wea = push, ram_aa = wptr, ram_dia = din.
  - wptr increments mod DEPTH on push. Wrap 8191 -> 0 is silent.
- RAM read issue: rd = (ram_cnt != 0) & (obuf_cnt + rd_pend - pop < 2).
  - pop = dout_valid & dout_ready.
  - ram_ceb = rd, ram_ab = rptr. rptr increments mod DEPTH on rd.
  - rd_pend <= rd.
- ram_cnt update: ram_cnt <= ram_cnt + push - rd; simultaneous push and rd leaves it unchanged. ram_cnt is never above DEPTH and never negative.
- Output buffer: 2 entries.
  - When rd_pend=1, ram_dob is written to the tail at the edge.
  - dout/dout_valid always reflect the head.
  - Pop and load in the same cycle: the head advances and the new word enters the correct slot, so ordering is preserved.
- Collisions: writes never target an unread address and reads never target an unwritten one. Same-cycle A write and B read hit different addresses because ram_cnt is strictly between 0 and DEPTH whenever both occur.
- Latency: a word pushed at edge k gives ram_ceb during cycle k..k+1. Data is captured at edge k+2, so dout_valid=1 after edge k+2 (2-clock fall-through into an empty FIFO).
- Throughput: sustained 1 word/clk in and out simultaneously.
- level: ram_cnt + rd_pend + obuf_cnt, registered. Maximum DEPTH+2.
- almost_full: registered compare of the next ram_cnt against AFULL.
- dout_ready with dout_valid=0: ignored. din_valid with din_ready=0: word is not taken, the producer must hold it.
- Reset mid-operation: all contents are discarded. Any RAM read in flight is dropped; rd_pend clears and no stale data reaches dout.

Test Plan:
- Reset, then push 0x0001 at edge k with dout_ready=1 -> ram_ceb high in cycle k..k+1; dout=0x0001, dout_valid=1 after edge k+2; level returns to 0 after the pop.
- Continuous push/pop of 0x0000..0x2FFF with dout_ready=1 -> output identical and in order, no bubbles after initial latency, pointers wrap at 8191->0.
- dout_ready=0, push until din_ready=0 -> exactly 8194 words accepted (level=8194, almost_full=1 from ram_cnt=7936); then drain all in order, level ends 0.
- At full, assert din_valid=1 and dout_ready=1 simultaneously -> no write while din_ready=0; din_ready returns 1 one edge after the first pop frees RAM; no lost or duplicated words.
- Random din_valid/dout_ready patterns (30-70% duty) over 100k words against a reference queue model -> exact data match, dout stable while dout_valid & !dout_ready.
- Assert rst for 1 cycle while rd_pend=1 and the buffer is full -> dout_valid=0, level=0, din_ready=0 then 1; next pushed word 0xA5A5 is the first word out.

Source files
------------

// File: rtl/ram_fifo_ctl.sv
// Stream FIFO controller around a dual-port block RAM: port A writes, port B reads,
// with a 2-entry first-word-fall-through output buffer that hides the RAM read latency.
module ram_fifo_ctl #(
    parameter int unsigned AW    = 13,
    parameter int unsigned DW    = 16,
    parameter int unsigned AFULL = 7936
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [AW:0]   level,
    output logic          almost_full,
    output logic [AW-1:0] ram_aa,
    output logic [DW-1:0] ram_dia,
    output logic          ram_cea,
    output logic          ram_wea,
    output logic [AW-1:0] ram_ab,
    output logic          ram_ceb,
    input  logic [DW-1:0] ram_dob
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] ram_cnt;
    logic [CW-1:0] ram_cnt_n;
    logic [CW-1:0] level_n;
    logic          rd_pend;
    logic [1:0]    obuf_cnt;
    logic [1:0]    obuf_cnt_n;
    logic [1:0]    cnt_after_pop;
    logic [DW-1:0] ob1;
    logic [DW-1:0] ob0_n;
    logic [DW-1:0] ob1_n;
    logic [2:0]    occ;
    logic          push;
    logic          pop;
    logic          rd;

    assign push = din_valid & din_ready;
    assign pop  = dout_valid & dout_ready;

    // Only fetch from RAM when the buffer has room for the word once it lands.
    always_comb begin
        occ       = 3'(obuf_cnt) + 3'(rd_pend) - 3'(pop);
        rd        = (ram_cnt != '0) && (occ < 3'd2);
        ram_cnt_n = ram_cnt + CW'(push) - CW'(rd);
    end

    assign ram_cea = push;
    assign ram_wea = push;
    assign ram_aa  = wptr;
    assign ram_dia = din;
    assign ram_ceb = rd;
    assign ram_ab  = rptr;

    // Output buffer: slot 0 (dout) is the head; arriving RAM data fills the first free slot after a pop.
    always_comb begin
        ob0_n         = dout;
        ob1_n         = ob1;
        cnt_after_pop = obuf_cnt - 2'(pop);
        if (pop) begin
            ob0_n = ob1;
        end
        if (rd_pend) begin
            if (cnt_after_pop == 2'd0) begin
                ob0_n = ram_dob;
            end else begin
                ob1_n = ram_dob;
            end
        end
        obuf_cnt_n = cnt_after_pop + 2'(rd_pend);
        level_n    = ram_cnt_n + CW'(rd) + CW'(obuf_cnt_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            ram_cnt     <= '0;
            rd_pend     <= 1'b0;
            obuf_cnt    <= 2'd0;
            dout        <= '0;
            ob1         <= '0;
            dout_valid  <= 1'b0;
            din_ready   <= 1'b0;
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (rd) begin
                rptr <= rptr + AW'(1);
            end
            ram_cnt     <= ram_cnt_n;
            rd_pend     <= rd;
            obuf_cnt    <= obuf_cnt_n;
            dout        <= ob0_n;
            ob1         <= ob1_n;
            dout_valid  <= (obuf_cnt_n != 2'd0);
            din_ready   <= (ram_cnt_n != CW'(DEPTH));
            level       <= level_n;
            almost_full <= (ram_cnt_n >= CW'(AFULL));
        end
    end

endmodule
